// File: rtl/kyber_pkg.sv
// Shared Kyber constants, legal coefficient widths and decoder state encoding.
// Also holds the small helpers used by the byte-stream decoder.
package kyber_pkg;
    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int BUF_W   = 88;

    localparam logic [3:0] L_1  = 4'd1;
    localparam logic [3:0] L_4  = 4'd4;
    localparam logic [3:0] L_5  = 4'd5;
    localparam logic [3:0] L_10 = 4'd10;
    localparam logic [3:0] L_11 = 4'd11;
    localparam logic [3:0] L_12 = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_legal_l(input logic [3:0] l);
        return (l == L_1) || (l == L_4) || (l == L_5) ||
               (l == L_10) || (l == L_11) || (l == L_12);
    endfunction

    // Only 12-bit coefficients can exceed q; one conditional subtract suffices.
    function automatic logic [11:0] reduce_coeff(input logic [11:0] c, input logic [3:0] l);
        if (l == L_12 && c >= 12'(KYBER_Q))
            return c - 12'(KYBER_Q);
        return c;
    endfunction
endpackage

// File: rtl/decode.sv
// Kyber ByteDecode_l: unpacks a 64-bit-per-word byte stream into coefficient pairs.
// One pair of l-bit coefficients leaves per cycle once enough bits are buffered.
module decode
    import kyber_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [63:0] i_ibytes,
    input  logic        i_ibytes_valid,
    output logic        o_ibytes_ready,
    input  logic [3:0]  i_l,
    output logic [23:0] o_coeffs,
    output logic        o_coeffs_valid,
    output logic        o_done
);
    state_t           state, state_nxt;
    logic [BUF_W-1:0] bit_buf, bit_buf_nxt, rem_buf;
    logic [6:0]       cnt_bits, cnt_bits_nxt, rem_cnt;
    logic [6:0]       pair_cnt, pair_cnt_nxt;
    logic [5:0]       words, words_nxt;
    logic [3:0]       l_reg, l_reg_nxt;
    logic [4:0]       two_l;
    logic [5:0]       word_lim;
    logic [11:0]      mask, c0, c1;
    logic             rdy, accept, extract;

    assign two_l    = {l_reg, 1'b0};
    assign word_lim = {l_reg, 2'b00};
    assign mask     = 12'((13'd1 << l_reg) - 13'd1);
    assign c0       = bit_buf[11:0] & mask;
    assign c1       = 12'(bit_buf >> l_reg) & mask;

    assign o_ibytes_ready = rdy;

    always_comb begin
        rdy          = 1'b0;
        extract      = 1'b0;
        state_nxt    = state;
        l_reg_nxt    = l_reg;
        pair_cnt_nxt = pair_cnt;
        words_nxt    = words;

        case (state)
            S_IDLE: rdy = i_rstn && is_legal_l(i_l);
            S_DEC: begin
                rdy     = i_rstn && (cnt_bits <= 7'd24) && (words < word_lim);
                extract = cnt_bits >= {2'b00, two_l};
            end
            default: ;
        endcase
        accept = rdy && i_ibytes_valid;

        rem_buf      = extract ? (bit_buf >> two_l) : bit_buf;
        rem_cnt      = extract ? (cnt_bits - {2'b00, two_l}) : cnt_bits;
        bit_buf_nxt  = rem_buf;
        cnt_bits_nxt = rem_cnt;
        // Buffer bits above cnt_bits are always zero, so OR-ing the new word in is safe.
        if (accept) begin
            bit_buf_nxt  = rem_buf | (BUF_W'(i_ibytes) << rem_cnt);
            cnt_bits_nxt = rem_cnt + 7'd64;
            words_nxt    = words + 6'd1;
        end

        case (state)
            S_IDLE: if (accept) begin
                l_reg_nxt = i_l;
                state_nxt = S_DEC;
            end
            S_DEC: if (extract) begin
                pair_cnt_nxt = pair_cnt + 7'd1;
                if (pair_cnt == 7'd127) state_nxt = S_DONE;
            end
            default: begin
                bit_buf_nxt  = '0;
                cnt_bits_nxt = '0;
                pair_cnt_nxt = '0;
                words_nxt    = '0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= S_IDLE;
            bit_buf        <= '0;
            cnt_bits       <= '0;
            pair_cnt       <= '0;
            words          <= '0;
            l_reg          <= L_12;
            o_coeffs       <= '0;
            o_coeffs_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_nxt;
            bit_buf        <= bit_buf_nxt;
            cnt_bits       <= cnt_bits_nxt;
            pair_cnt       <= pair_cnt_nxt;
            words          <= words_nxt;
            l_reg          <= l_reg_nxt;
            o_coeffs_valid <= extract;
            o_done         <= (state == S_DONE);
            if (extract)
                o_coeffs <= {reduce_coeff(c1, l_reg), reduce_coeff(c0, l_reg)};
        end
    end
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a bit-stream model predicts every pair, one
// negedge process compares outputs, handshake bounds and the done pulse.
module tb_decode;
    import kyber_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [63:0] i_ibytes = '0;
    logic        i_ibytes_valid = 1'b0;
    logic [3:0]  i_l = 4'd12;
    logic        o_ibytes_ready;
    logic [23:0] o_coeffs;
    logic        o_coeffs_valid;
    logic        o_done;

    decode dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_ibytes       (i_ibytes),
        .i_ibytes_valid (i_ibytes_valid),
        .o_ibytes_ready (o_ibytes_ready),
        .i_l            (i_l),
        .o_coeffs       (o_coeffs),
        .o_coeffs_valid (o_coeffs_valid),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_pairs [128];
    logic [63:0] words [48];
    int          coeffs [256];
    int          cur_l = 12;
    int          acc = 0;
    int          valids = 0;
    int          samp = 0;
    int          first_acc_samp = -1;
    int          done_cnt = 0;
    logic [23:0] last_coeffs = '0;
    logic [23:0] first_pair = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Coefficient i occupies stream bits [i*l, i*l+l).
    function automatic void model_from_words(input int l);
        logic [3071:0] s;
        for (int k = 0; k < 48; k++) s[64*k +: 64] = words[k];
        for (int p = 0; p < 128; p++) begin
            int ca, cb;
            ca = 0;
            cb = 0;
            for (int b = 0; b < l; b++) begin
                ca |= int'(s[(2*p)*l + b]) << b;
                cb |= int'(s[(2*p+1)*l + b]) << b;
            end
            if (l == 12 && ca >= KYBER_Q) ca -= KYBER_Q;
            if (l == 12 && cb >= KYBER_Q) cb -= KYBER_Q;
            exp_pairs[p] = {12'(cb), 12'(ca)};
        end
    endfunction

    task automatic random_words();
        for (int k = 0; k < 48; k++) words[k] = {$urandom, $urandom};
    endtask

    // Round trip: pick coefficients, encode them into the word stream, expect them back.
    task automatic encode_random(input int l);
        logic [3071:0] s;
        int maxv;
        s = '0;
        maxv = (l == 12) ? KYBER_Q - 1 : (1 << l) - 1;
        for (int i = 0; i < 256; i++) begin
            coeffs[i] = int'($urandom_range(0, maxv));
            for (int b = 0; b < l; b++) s[i*l + b] = coeffs[i][b];
        end
        for (int k = 0; k < 48; k++) words[k] = s[64*k +: 64];
        for (int p = 0; p < 128; p++) exp_pairs[p] = {12'(coeffs[2*p+1]), 12'(coeffs[2*p])};
    endtask

    task automatic pulse_reset();
        i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;
    endtask

    // Called at posedge+1; feeds 4*l words, then waits for o_done.
    // stop_after > 0 aborts with a reset once that many pairs have been seen.
    task automatic run_poly(input int l, input bit gaps, input int stop_after);
        int w, guard, d0;
        bit acc_now, stop;
        w = 0;
        guard = 0;
        stop = 0;
        d0 = done_cnt;
        cur_l = l;
        i_l = 4'(l);
        while (w < 4*l && !stop) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_ibytes_valid = 1'b0;
                i_ibytes = {$urandom, $urandom};
            end else begin
                i_ibytes_valid = 1'b1;
                i_ibytes = words[w];
            end
            @(negedge i_clk);
            acc_now = i_ibytes_valid && o_ibytes_ready;
            @(posedge i_clk);
            #1;
            if (acc_now) w++;
            if (stop_after > 0 && valids >= stop_after) stop = 1;
            guard++;
            if (guard > 3000) begin
                fail_now("feed_timeout");
                stop = 1;
            end
        end
        i_ibytes_valid = 1'b0;
        if (stop_after > 0) begin
            pulse_reset();
            return;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 400) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        samp++;
        if (!i_rstn) begin
            check("rst_ready", 64'(o_ibytes_ready), 64'd0);
            check("rst_coeffs", 64'(o_coeffs), 64'd0);
            check("rst_valid", 64'(o_coeffs_valid), 64'd0);
            check("rst_done", 64'(o_done), 64'd0);
            acc = 0;
            valids = 0;
            first_acc_samp = -1;
            last_coeffs = '0;
        end else begin
            if (o_coeffs_valid) begin
                if (valids >= 128) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pair: got %0h after 128 pairs", o_coeffs);
                end else begin
                    check("pair", 64'(o_coeffs), 64'(exp_pairs[valids]));
                end
                if (valids == 0) begin
                    first_pair = o_coeffs;
                    check("first_latency", 64'(samp - first_acc_samp), 64'd2);
                end
                valids++;
            end else begin
                check("hold", 64'(o_coeffs), 64'(last_coeffs));
            end
            last_coeffs = o_coeffs;
            if (o_done) begin
                check("done_pairs", 64'(valids), 64'd128);
                check("done_words", 64'(acc), 64'(4*cur_l));
                done_cnt++;
                acc = 0;
                valids = 0;
                first_acc_samp = -1;
            end
            if (acc == 0) begin
                check("idle_ready", 64'(o_ibytes_ready), 64'(is_legal_l(i_l)));
            end else if (o_ibytes_ready) begin
                check("ready_bits", 64'((64*acc - 2*cur_l*valids) <= 24), 64'd1);
                check("ready_words", 64'(acc < 4*cur_l), 64'd1);
            end
            if (i_ibytes_valid && o_ibytes_ready) begin
                if (acc == 0) first_acc_samp = samp;
                acc++;
            end
        end
    end

    initial begin
        int ls [6];
        ls = '{1, 4, 5, 10, 11, 12};
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;

        // Illegal width: ready must stay low and nothing is consumed.
        i_l = 4'd3;
        i_ibytes_valid = 1'b1;
        i_ibytes = 64'hDEAD_BEEF_0000_0001;
        repeat (3) begin
            @(negedge i_clk);
            check("illegal_ready", 64'(o_ibytes_ready), 64'd0);
            @(posedge i_clk);
            #1;
        end
        i_ibytes_valid = 1'b0;

        // l=4, single nonzero word.
        for (int k = 0; k < 48; k++) words[k] = '0;
        words[0] = 64'h0000_0000_0000_0021;
        model_from_words(4);
        check("model_l4_pair0", 64'(exp_pairs[0]), 64'h002001);
        run_poly(4, 0, 0);
        check("l4_first", 64'(first_pair), 64'h002001);

        // l=12 all ones: 4095 reduces to 766.
        for (int k = 0; k < 48; k++) words[k] = '1;
        model_from_words(12);
        check("model_l12_pair127", 64'(exp_pairs[127]), 64'h2FE2FE);
        run_poly(12, 0, 0);
        check("l12_first", 64'(first_pair), 64'h2FE2FE);

        // l=1, word0=1.
        for (int k = 0; k < 48; k++) words[k] = '0;
        words[0] = 64'h1;
        model_from_words(1);
        check("model_l1_pair1", 64'(exp_pairs[1]), 64'h000000);
        run_poly(1, 0, 0);
        check("l1_first", 64'(first_pair), 64'h000001);

        // l=11 random data with valid gaps.
        random_words();
        model_from_words(11);
        run_poly(11, 1, 0);

        // Reset part-way through l=10, then a clean l=5 polynomial.
        random_words();
        model_from_words(10);
        run_poly(10, 0, 40);
        check("post_rst_valid", 64'(o_coeffs_valid), 64'd0);
        random_words();
        model_from_words(5);
        run_poly(5, 1, 0);

        // Encode/decode round trip for every legal width.
        foreach (ls[i]) begin
            encode_random(ls[i]);
            run_poly(ls[i], (i % 2) == 1, 0);
        end

        check("total_done", 64'(done_cnt), 64'd11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
